mdu: RTL and testbench
======================

# mdu

Iterative RV32M multiply/divide unit in the execute stage, next to the ALU. It takes the same operand bus as the ALU (`I_data1`, `I_data2`) and drives the execute result mux alongside `O_data` of the ALU. It computes all eight M-extension operations with a shift-add multiplier and a restoring divider, one bit per cycle. A start/busy/done handshake lets the pipeline stall around it.

## Interface
Parameters:
- none. Width is fixed at 32 bits, and the iteration count is fixed at 32.

Ports:
- `I_clk`: input, 1 bit. Clock. Everything updates on the rising edge.
- `I_rst`: input, 1 bit. Reset. One clock, synchronous, active-high.
- `I_start`: input, 1 bit. Requests an operation. Sampled only while `O_busy` = 0.
- `I_mdusel`: input, 3 bits. Operation select, encoded as RV32M funct3:
  - 0 `MUL`, 1 `MULH`, 2 `MULHSU`, 3 `MULHU`
  - 4 `DIV`, 5 `DIVU`, 6 `REM`, 7 `REMU`
- `I_data1`: input, 32 bits. rs1 operand: multiplicand or dividend.
- `I_data2`: input, 32 bits. rs2 operand: multiplier or divisor.
- `O_data`: output, 32 bits. Result. Registered, and held until the next `O_done`.
- `O_busy`: output, 1 bit. High while an operation is in progress.
- `O_done`: output, 1 bit. Single-cycle pulse. `O_data` is valid on the same cycle.

## Operation
- FSM states are IDLE, CALC, FIN.
- **IDLE**
  - When `I_start` = 1, the unit latches `I_mdusel`, `I_data1` and `I_data2`.
  - It computes operand magnitudes and the result sign:
    - `MULH` and `DIV`/`REM`: both operands signed.
    - `MULHSU`: rs1 signed, rs2 unsigned.
    - All others: unsigned.
  - It loads the 5-bit iteration counter with 31, sets `O_busy`, and goes to CALC.
  - A special case goes straight to FIN with the result preloaded.
- **CALC, multiply**
  - Uses a 64-bit accumulator over the unsigned magnitudes.
  - Each cycle: if the multiplier LSB is 1, add the multiplicand into the upper half, then shift right by 1.
- **CALC, divide**
  - Restoring division with a 33-bit partial remainder.
  - Each cycle: shift in the next dividend bit and trial-subtract the divisor magnitude. If the result is non-negative, keep it and shift 1 into the quotient; otherwise shift in 0.
- **CALC exit:** after the counter passes 0 (32 iterations), go to FIN.
- **FIN**
  - Multiply sign fix: negate the 64-bit product if the result sign is negative.
    - `MUL` returns bits [31:0].
    - `MULH`, `MULHSU` and `MULHU` return bits [63:32].
  - Divide sign fix: the quotient is negated if the operand signs differ. The remainder takes the sign of the dividend.
  - Register `O_data`, pulse `O_done`, clear `O_busy`, and return to IDLE.
- **Special cases** (detected in IDLE; no CALC cycles):
  - Divisor = 0:
    - `DIV`/`DIVU` return 0xFFFFFFFF.
    - `REM`/`REMU` return the dividend unchanged.
  - Signed overflow (rs1 = 0x80000000, rs2 = 0xFFFFFFFF):
    - `DIV` returns 0x80000000.
    - `REM` returns 0.
- All arithmetic is modulo 2^32 on the output. Internal magnitudes are 32 bits unsigned; |0x80000000| = 0x80000000 is represented exactly.

## Timing
- **Reset values:** `O_data` = 0, `O_busy` = 0, `O_done` = 0, state = IDLE. Reset mid-operation aborts immediately, and no `O_done` follows.
- **Normal latency:** `I_start` sampled at edge E0, iterations on E1..E32, result registered on E33.
  - `O_busy` is high from E0 to E33.
  - `O_done` is high for one cycle starting at E33.
  - Start to done is 33 cycles.
- **Special-case latency:** the result is registered on E1, and `O_done` is high for one cycle after E1. `O_busy` is high only from E0 to E1.
- **Inputs during an operation:** `I_start` is ignored while `O_busy` = 1. Operand and `I_mdusel` changes after E0 have no effect.
- **Back-to-back:** `O_busy` = 0 on the `O_done` cycle, so an `I_start` asserted on that cycle is accepted.
- **Hold:** `O_data` keeps its value across idle cycles until the next FIN.
- **Reset priority:** `I_rst` takes priority over `I_start` on the same edge.

## Test plan
- **Basic multiply.** `MUL` 7×2 gives 14, with `O_done` exactly 33 cycles after start and `O_busy` high throughout. `MUL` 0xFFFFFFFD×3 (-3×3) gives 0xFFFFFFF7.
- **High-half multiplies:**
  - `MULHU` 0xFFFFFFFF×0xFFFFFFFF gives 0xFFFFFFFE.
  - `MULH` 0xFFFFFFFF×0xFFFFFFFF gives 0.
  - `MULHSU` 0xFFFFFFFF×0xFFFFFFFF gives 0xFFFFFFFF.
  - `MULH` 0x80000000×0x80000000 gives 0x40000000.
- **Signed and unsigned divide:**
  - `DIV` -7/2 gives 0xFFFFFFFD (-3).
  - `REM` -7/2 gives 0xFFFFFFFF (-1).
  - `DIVU` 7/2 gives 3.
  - `REMU` 0xFFFFFFF9/2 gives 1.
- **Corner cases** (each must give `O_done` 1 cycle after start):
  - `DIV` 5/0 gives 0xFFFFFFFF.
  - `REMU` 5/0 gives 5.
  - `DIV` 0x80000000/0xFFFFFFFF gives 0x80000000.
  - `REM` of the same operands gives 0.
- **Handshake:**
  - Pulse `I_start` again at cycle 10 of a `MUL` 3×5. Only one `O_done` occurs, with result 15.
  - Assert `I_start` with `DIVU` 100/7 on the `O_done` cycle. It is accepted, and the unit returns 14 after 33 more cycles.
- **Reset mid-operation:**
  - Assert `I_rst` at cycle 16 of a `DIV`. Next cycle: `O_busy` = 0 and `O_data` = 0, with no `O_done`.
  - A new `MUL` 6×7 then returns 42.

Source files
------------

// File: rtl/mdu.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide.
// One bit per cycle, start/busy/done handshake for pipeline stalls.
module mdu (
  input  logic        I_clk,
  input  logic        I_rst,
  input  logic        I_start,
  input  logic [2:0]  I_mdusel,
  input  logic [31:0] I_data1,
  input  logic [31:0] I_data2,
  output logic [31:0] O_data,
  output logic        O_busy,
  output logic        O_done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  logic [1:0]  r_state;
  logic [2:0]  r_op;
  logic        r_neg;
  logic        r_rneg;
  logic [4:0]  r_cnt;
  logic [31:0] r_mcand;
  logic [63:0] r_acc;
  logic [32:0] r_rem;
  logic        r_spec;
  logic [31:0] r_sres;
  logic [31:0] r_data;
  logic        r_busy;
  logic        r_done;

  logic        w_s1;
  logic        w_s2;
  logic        w_an;
  logic        w_bn;
  logic [31:0] w_amag;
  logic [31:0] w_bmag;
  logic        w_div0;
  logic        w_ovf;
  logic [31:0] w_sres;
  logic [32:0] w_sum;
  logic [33:0] w_shl;
  logic [33:0] w_diff;
  logic [63:0] w_prod;
  logic [31:0] w_quo;
  logic [31:0] w_rm;
  logic [31:0] w_res;

  assign w_s1 = (I_mdusel == 3'd1) || (I_mdusel == 3'd2) ||
                (I_mdusel == 3'd4) || (I_mdusel == 3'd6);
  assign w_s2 = (I_mdusel == 3'd1) || (I_mdusel == 3'd4) ||
                (I_mdusel == 3'd6);
  assign w_an = w_s1 & I_data1[31];
  assign w_bn = w_s2 & I_data2[31];
  assign w_amag = w_an ? (~I_data1 + 32'd1) : I_data1;
  assign w_bmag = w_bn ? (~I_data2 + 32'd1) : I_data2;

  assign w_div0 = I_mdusel[2] && (I_data2 == 32'd0);
  assign w_ovf  = ((I_mdusel == 3'd4) || (I_mdusel == 3'd6)) &&
                  (I_data1 == 32'h8000_0000) &&
                  (I_data2 == 32'hFFFF_FFFF);
  assign w_sres = w_div0 ? (I_mdusel[1] ? I_data1 : 32'hFFFF_FFFF)
                         : (I_mdusel[1] ? 32'd0 : 32'h8000_0000);

  // multiply step: carry out of the upper-half add shifts back in
  assign w_sum = {1'b0, r_acc[63:32]} +
                 {1'b0, (r_acc[0] ? r_mcand : 32'd0)};

  // divide step: lower half of r_acc shifts dividend out, quotient in
  assign w_shl  = {r_rem, r_acc[31]};
  assign w_diff = w_shl - {2'b00, r_mcand};

  assign w_prod = r_neg ? (~r_acc + 64'd1) : r_acc;
  assign w_quo  = r_neg ? (~r_acc[31:0] + 32'd1) : r_acc[31:0];
  assign w_rm   = r_rneg ? (~r_rem[31:0] + 32'd1) : r_rem[31:0];

  always_comb begin
    w_res = 32'd0;
    if (r_spec) begin
      w_res = r_sres;
    end else begin
      case (r_op)
        3'd0:    w_res = w_prod[31:0];
        3'd1,
        3'd2,
        3'd3:    w_res = w_prod[63:32];
        3'd4,
        3'd5:    w_res = w_quo;
        default: w_res = w_rm;
      endcase
    end
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      r_state <= S_IDLE;
      r_op    <= 3'd0;
      r_neg   <= 1'b0;
      r_rneg  <= 1'b0;
      r_cnt   <= 5'd0;
      r_mcand <= 32'd0;
      r_acc   <= 64'd0;
      r_rem   <= 33'd0;
      r_spec  <= 1'b0;
      r_sres  <= 32'd0;
      r_data  <= 32'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (I_start) begin
            r_op    <= I_mdusel;
            r_neg   <= w_an ^ w_bn;
            r_rneg  <= w_an;
            r_cnt   <= 5'd31;
            r_mcand <= I_mdusel[2] ? w_bmag : w_amag;
            r_acc   <= {32'd0, (I_mdusel[2] ? w_amag : w_bmag)};
            r_rem   <= 33'd0;
            r_spec  <= w_div0 | w_ovf;
            r_sres  <= w_sres;
            r_busy  <= 1'b1;
            r_state <= (w_div0 | w_ovf) ? S_FIN : S_CALC;
          end
        end
        S_CALC: begin
          if (r_op[2]) begin
            if (!w_diff[33]) begin
              r_rem <= w_diff[32:0];
              r_acc <= {r_acc[63:32], r_acc[30:0], 1'b1};
            end else begin
              r_rem <= w_shl[32:0];
              r_acc <= {r_acc[63:32], r_acc[30:0], 1'b0};
            end
          end else begin
            r_acc <= {w_sum, r_acc[31:1]};
          end
          if (r_cnt == 5'd0) begin
            r_state <= S_FIN;
          end else begin
            r_cnt <= r_cnt - 5'd1;
          end
        end
        S_FIN: begin
          r_data  <= w_res;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign O_data = r_data;
  assign O_busy = r_busy;
  assign O_done = r_done;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed table, random ops against an
// arithmetic reference model, and handshake/reset sequences.
module tb_mdu;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  sel;
  logic [31:0] d1;
  logic [31:0] d2;
  logic [31:0] q;
  logic        busy;
  logic        done;

  int checks;
  int failures;

  mdu dut (
    .I_clk(clk),
    .I_rst(rst),
    .I_start(start),
    .I_mdusel(sel),
    .I_data1(d1),
    .I_data2(d2),
    .O_data(q),
    .O_busy(busy),
    .O_done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  function automatic logic [31:0] ref_mdu(input logic [2:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa;
    longint sb;
    longint ua;
    longint ub;
    logic [63:0] p;
    int ia;
    int ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    ia = a;
    ib = b;
    p = 64'd0;
    case (op)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(ia / ib);
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(ia % ib);
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] op,
                                 input logic [31:0] a,
                                 input logic [31:0] b);
    if (op[2] && b == 0) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 &&
        b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // drive start now; after the accepting edge, scramble operands
  task automatic start_now(input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b);
    sel = op;
    d1 = a;
    d2 = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    sel = 3'($urandom);
    d1 = $urandom;
    d2 = $urandom;
  endtask

  task automatic start_op(input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b);
    @(negedge clk);
    start_now(op, a, b);
  endtask

  task automatic wait_done(output int lat, output logic busy_ok);
    lat = 99;
    busy_ok = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        if (busy) busy_ok = 1'b0;
        break;
      end
      if (!busy) busy_ok = 1'b0;
    end
  endtask

  task automatic run_check(input string name, input logic [2:0] op,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp, input int elat);
    int lat;
    logic bok;
    start_op(op, a, b);
    check({name, " busy_at_start"}, 32'(busy), 32'd1);
    wait_done(lat, bok);
    check({name, " latency"}, 32'(lat), 32'(elat));
    check({name, " busy_profile"}, 32'(bok), 32'd1);
    check({name, " data"}, q, exp);
  endtask

  vec_t tbl[14];

  initial begin
    int lat;
    int nd;
    logic bok;
    logic [31:0] cap;
    logic [2:0] rop;
    logic [31:0] ra;
    logic [31:0] rb;

    checks = 0;
    failures = 0;
    rst = 1'b1;
    start = 1'b0;
    sel = 3'd0;
    d1 = 32'd0;
    d2 = 32'd0;

    tbl[0]  = '{3'd0, 32'd7, 32'd2, 32'd14, 33};
    tbl[1]  = '{3'd0, 32'hFFFF_FFFD, 32'd3, 32'hFFFF_FFF7, 33};
    tbl[2]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
    tbl[3]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 33};
    tbl[4]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33};
    tbl[5]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33};
    tbl[6]  = '{3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33};
    tbl[7]  = '{3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33};
    tbl[8]  = '{3'd5, 32'd7, 32'd2, 32'd3, 33};
    tbl[9]  = '{3'd7, 32'hFFFF_FFF9, 32'd2, 32'd1, 33};
    tbl[10] = '{3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 1};
    tbl[11] = '{3'd7, 32'd5, 32'd0, 32'd5, 1};
    tbl[12] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
    tbl[13] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1};

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset data", q, 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);

    for (int i = 0; i < 14; i++) begin
      run_check($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b,
                tbl[i].exp, tbl[i].lat);
    end

    // result holds across idle cycles
    cap = q;
    repeat (5) @(posedge clk);
    #1;
    check("hold data", q, 32'd0);
    check("hold no_done", 32'(done), 32'd0);

    for (int i = 0; i < 60; i++) begin
      rop = 3'($urandom);
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        3: ra = 32'h8000_0000;
        default: ;
      endcase
      run_check($sformatf("rnd%0d op%0d", i, rop), rop, ra, rb,
                ref_mdu(rop, ra, rb), ref_lat(rop, ra, rb));
    end

    // second start mid-operation is ignored
    start_op(3'd0, 32'd3, 32'd5);
    nd = 0;
    lat = 99;
    cap = 32'd0;
    for (int i = 1; i <= 45; i++) begin
      if (i == 10) begin
        sel = 3'd0;
        d1 = 32'd9;
        d2 = 32'd9;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      if (done) begin
        nd++;
        if (nd == 1) begin
          lat = i;
          cap = q;
        end
      end
    end
    start = 1'b0;
    check("restart done_count", 32'(nd), 32'd1);
    check("restart latency", 32'(lat), 32'd33);
    check("restart data", cap, 32'd15);

    // start accepted on the done cycle
    start_op(3'd3, 32'h1234_5678, 32'h9ABC_DEF0);
    wait_done(lat, bok);
    check("b2b first latency", 32'(lat), 32'd33);
    check("b2b first data", q, ref_mdu(3'd3, 32'h1234_5678, 32'h9ABC_DEF0));
    start_now(3'd5, 32'd100, 32'd7);
    check("b2b accepted busy", 32'(busy), 32'd1);
    wait_done(lat, bok);
    check("b2b second latency", 32'(lat), 32'd33);
    check("b2b second data", q, 32'd14);

    // reset mid-divide aborts without done
    start_op(3'd4, 32'd1000, 32'd7);
    repeat (15) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst data", q, 32'd0);
    check("midrst done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) nd++;
    end
    check("midrst no_done", 32'(nd), 32'd0);
    run_check("post_rst mul", 3'd0, 32'd6, 32'd7, 32'd42, 33);

    // reset wins over start on the same edge
    @(negedge clk);
    rst = 1'b1;
    sel = 3'd0;
    d1 = 32'd2;
    d2 = 32'd2;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    rst = 1'b0;
    check("rst_prio busy", 32'(busy), 32'd0);
    check("rst_prio data", q, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
